// File: rtl/iob_ila_capture_pkg.sv
// iob_ila_capture_pkg
//   Shared definitions for the ILA capture block: FSM state encodings
//   (these values are visible on state_o) and the width helper for the
//   software read-slice select.
package iob_ila_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } ila_state_e;

  // Number of bits needed to select one DATA_W slice of a SIGNAL_W sample.
  // Never below 1 so the select port always exists.
  function automatic int ila_sel_w(input int signal_w, input int data_w);
    int n;
    n = (signal_w + data_w - 1) / data_w;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iob_ila_trig_eval.sv
// iob_ila_trig_eval
//   Combinational trigger evaluation.
//   trigger_i  raw trigger bits
//   mask_i     1 = bit participates
//   negate_i   1 = bit inverted before evaluation
//   mode_i     0 = OR of enabled bits, 1 = AND of enabled bits
//   hit_o      trigger condition met (never with an all-zero mask)
module iob_ila_trig_eval #(
  parameter int TRIGGER_W = 4
) (
  input  logic [TRIGGER_W-1:0] trigger_i,
  input  logic [TRIGGER_W-1:0] mask_i,
  input  logic [TRIGGER_W-1:0] negate_i,
  input  logic                 mode_i,
  output logic                 hit_o
);

  logic [TRIGGER_W-1:0] eff;
  logic                 or_hit, and_hit;

  assign eff     = trigger_i ^ negate_i;
  assign or_hit  = |(eff & mask_i);
  // Masked-off bits are forced to 1 so they do not block the AND; an empty
  // mask would otherwise be a permanent hit.
  assign and_hit = (&(eff | ~mask_i)) & (|mask_i);
  assign hit_o   = mode_i ? and_hit : or_hit;

endmodule

// File: rtl/iob_ram_2p.sv
// iob_ram_2p
//   Simple dual-port RAM, one write port and one registered read port,
//   single clock. Contents are not reset.
//   clk_i            clock
//   w_en_i/w_addr_i/w_data_i   write port
//   r_en_i/r_addr_i  read request; r_data_o valid one cycle later
module iob_ram_2p #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              w_en_i,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic [DATA_W-1:0] w_data_i,
  input  logic              r_en_i,
  input  logic [ADDR_W-1:0] r_addr_i,
  output logic [DATA_W-1:0] r_data_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (w_en_i) mem[w_addr_i] <= w_data_i;
    if (r_en_i) r_data_o <= mem[r_addr_i];
  end

endmodule

// File: rtl/iob_ila_capture.sv
// iob_ila_capture
//   Integrated logic analyser capture core. After arm_i it fills a
//   pre-trigger window, keeps it rolling until the trigger fires, then
//   stores the post-trigger samples and stops in DONE for readout.
//   clk_i/cke_i/arst_i        clock, clock enable, async active-high reset
//   signal_i                  sampled bus
//   trigger_i, trig_mask_i, trig_negate_i, trig_mode_i   trigger setup
//   arm_i, abort_i            start / cancel pulses
//   pretrig_i, posttrig_i     window sizes (latched at arm)
//   state_o, done_o           FSM state and DONE flag
//   n_samples_o, trig_pos_o   stored sample count, trigger sample index
//   rd_index_i, rd_sel_i      readout address (0 = oldest) and slice
//   rd_data_o                 readout data, one cycle after the request
module iob_ila_capture
  import iob_ila_capture_pkg::*;
#(
  parameter  int SIGNAL_W  = 32,
  parameter  int TRIGGER_W = 4,
  parameter  int BUFFER_W  = 10,
  parameter  int DATA_W    = 32,
  localparam int SEL_W     = ila_sel_w(SIGNAL_W, DATA_W)
) (
  input  logic                 clk_i,
  input  logic                 cke_i,
  input  logic                 arst_i,
  input  logic [SIGNAL_W-1:0]  signal_i,
  input  logic [TRIGGER_W-1:0] trigger_i,
  input  logic [TRIGGER_W-1:0] trig_mask_i,
  input  logic [TRIGGER_W-1:0] trig_negate_i,
  input  logic                 trig_mode_i,
  input  logic                 arm_i,
  input  logic                 abort_i,
  input  logic [BUFFER_W-1:0]  pretrig_i,
  input  logic [BUFFER_W-1:0]  posttrig_i,
  output logic [2:0]           state_o,
  output logic                 done_o,
  output logic [BUFFER_W:0]    n_samples_o,
  output logic [BUFFER_W-1:0]  trig_pos_o,
  input  logic [BUFFER_W-1:0]  rd_index_i,
  input  logic [SEL_W-1:0]     rd_sel_i,
  output logic [DATA_W-1:0]    rd_data_o
);

  localparam int NSL   = (SIGNAL_W + DATA_W - 1) / DATA_W;
  localparam int PAD_W = (2**SEL_W) * DATA_W;
  localparam logic [SEL_W:0] NSL_V = (SEL_W+1)'(NSL);

  ila_state_e          state_q, state_d;
  logic [BUFFER_W-1:0] wptr_q, wptr_d, optr_q, optr_d;
  logic [BUFFER_W-1:0] pre_q, pre_d, post_q, post_d, pcnt_q, pcnt_d;
  logic [BUFFER_W-1:0] tpos_q, tpos_d;
  logic [BUFFER_W:0]   cnt_q, cnt_d;
  logic                we, hit;
  logic [BUFFER_W-1:0] post_lim, post_clamp;
  logic                rd_ok_q;
  logic [SEL_W-1:0]    rd_sel_q;
  logic [SIGNAL_W-1:0] ram_dout;
  logic [PAD_W-1:0]    rd_pad;

  iob_ila_trig_eval #(.TRIGGER_W(TRIGGER_W)) u_trig (
    .trigger_i (trigger_i),
    .mask_i    (trig_mask_i),
    .negate_i  (trig_negate_i),
    .mode_i    (trig_mode_i),
    .hit_o     (hit)
  );

  // A BUFFER_W-bit pretrig is already <= DEPTH-1; posttrig is limited so
  // pre + 1 + post never exceeds DEPTH and the trigger sample survives.
  assign post_lim   = {BUFFER_W{1'b1}} - pretrig_i;
  assign post_clamp = (posttrig_i > post_lim) ? post_lim : posttrig_i;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    optr_d  = optr_q;
    cnt_d   = cnt_q;
    tpos_d  = tpos_q;
    pre_d   = pre_q;
    post_d  = post_q;
    pcnt_d  = pcnt_q;
    we      = 1'b0;
    if (abort_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm_i) begin
            state_d = ST_PRE;
            wptr_d  = '0;
            optr_d  = '0;
            cnt_d   = '0;
            tpos_d  = '0;
            pcnt_d  = '0;
            pre_d   = pretrig_i;
            post_d  = post_clamp;
          end
        end
        ST_PRE: begin
          // Only reachable with an empty pre-window (pretrig = 0).
          if (cnt_q == {1'b0, pre_q}) begin
            state_d = ST_WAIT;
          end else begin
            we     = 1'b1;
            wptr_d = wptr_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_d == {1'b0, pre_q}) state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          we     = 1'b1;
          wptr_d = wptr_q + 1'b1;
          if (hit) begin
            cnt_d   = cnt_q + 1'b1;
            tpos_d  = pre_q;
            state_d = (post_q == '0) ? ST_DONE : ST_POST;
          end else begin
            // Rolling window: drop the oldest so count stays at pretrig.
            optr_d = optr_q + 1'b1;
          end
        end
        ST_POST: begin
          we     = 1'b1;
          wptr_d = wptr_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
          pcnt_d = pcnt_q + 1'b1;
          if (pcnt_d == post_q) state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= ST_IDLE;
      wptr_q   <= '0;
      optr_q   <= '0;
      cnt_q    <= '0;
      tpos_q   <= '0;
      pre_q    <= '0;
      post_q   <= '0;
      pcnt_q   <= '0;
      rd_ok_q  <= 1'b0;
      rd_sel_q <= '0;
    end else if (cke_i) begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      optr_q   <= optr_d;
      cnt_q    <= cnt_d;
      tpos_q   <= tpos_d;
      pre_q    <= pre_d;
      post_q   <= post_d;
      pcnt_q   <= pcnt_d;
      rd_ok_q  <= ({1'b0, rd_index_i} < cnt_q) && ({1'b0, rd_sel_i} < NSL_V);
      rd_sel_q <= rd_sel_i;
    end
  end

  iob_ram_2p #(.DATA_W(SIGNAL_W), .ADDR_W(BUFFER_W)) u_buf (
    .clk_i    (clk_i),
    .w_en_i   (we & cke_i),
    .w_addr_i (wptr_q),
    .w_data_i (signal_i),
    .r_en_i   (cke_i),
    .r_addr_i (optr_q + rd_index_i),
    .r_data_o (ram_dout)
  );

  // The RAM output register provides the one-cycle latency; the registered
  // valid flag zeroes the result out of reset and for out-of-range requests.
  assign rd_pad      = PAD_W'(ram_dout);
  assign rd_data_o   = rd_ok_q ? rd_pad[rd_sel_q*DATA_W +: DATA_W] : '0;

  assign state_o     = state_q;
  assign done_o      = (state_q == ST_DONE);
  assign n_samples_o = cnt_q;
  assign trig_pos_o  = tpos_q;

endmodule

// File: tb/tb_iob_ila_capture.sv
// tb_iob_ila_capture
//   Directed bench for iob_ila_capture with a 40-bit signal bus read as
//   two 32-bit slices. The sampled bus is {8'hC3, sigv}, where sigv is a
//   bench counter reset at each arm and advanced after every clock edge.
module tb_iob_ila_capture;

  localparam int SW = 40, TW = 4, BW = 10, DW = 32, SELW = 1;

  logic            clk = 1'b0, cke, arst;
  logic [SW-1:0]   sig;
  logic [TW-1:0]   trig, mask, neg;
  logic            mode, arm_i, abort_i;
  logic [BW-1:0]   pretrig, posttrig, tpos, rd_index;
  logic [2:0]      state;
  logic            done;
  logic [BW:0]     nsmp;
  logic [SELW-1:0] rd_sel;
  logic [DW-1:0]   rd_data, d;
  logic [31:0]     sigv;
  int              n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;
  always_comb sig = {8'hC3, sigv};

  iob_ila_capture #(.SIGNAL_W(SW), .TRIGGER_W(TW), .BUFFER_W(BW), .DATA_W(DW)) dut (
    .clk_i(clk), .cke_i(cke), .arst_i(arst), .signal_i(sig),
    .trigger_i(trig), .trig_mask_i(mask), .trig_negate_i(neg), .trig_mode_i(mode),
    .arm_i(arm_i), .abort_i(abort_i), .pretrig_i(pretrig), .posttrig_i(posttrig),
    .state_o(state), .done_o(done), .n_samples_o(nsmp), .trig_pos_o(tpos),
    .rd_index_i(rd_index), .rd_sel_i(rd_sel), .rd_data_o(rd_data)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sigv = sigv + 1;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic arm(input int pre, input int post);
    pretrig  = BW'(pre);
    posttrig = BW'(post);
    sigv     = 0;
    arm_i    = 1'b1;
    tick();
    arm_i    = 1'b0;
  endtask

  task automatic rd(input int idx, input int sel, output logic [DW-1:0] q);
    rd_index = BW'(idx);
    rd_sel   = SELW'(sel);
    tick();
    q = rd_data;
  endtask

  initial begin
    cke = 1'b1; arst = 1'b0; sigv = 0; trig = '0; mask = 4'b0001; neg = '0;
    mode = 1'b0; arm_i = 1'b0; abort_i = 1'b0; pretrig = '0; posttrig = '0;
    rd_index = '0; rd_sel = '0;
    #1 arst = 1'b1;
    #11;
    chk("rst_state", state, 0);
    chk("rst_done", done, 0);
    chk("rst_nsmp", nsmp, 0);
    chk("rst_tpos", tpos, 0);
    chk("rst_rd", rd_data, 0);
    @(posedge clk); #1 arst = 1'b0;

    // Basic capture: pre 4, post 3, trigger on sample 20.
    arm(4, 3);
    chk("c1_pre", state, 1);
    tickn(4);
    chk("c1_wait", state, 2);
    chk("c1_wait_n", nsmp, 4);
    tickn(15);
    chk("c1_roll_n", nsmp, 4);
    trig = 4'b0001; tick(); trig = '0;
    chk("c1_post", state, 3);
    chk("c1_tpos", tpos, 4);
    tickn(3);
    chk("c1_state", state, 4);
    chk("c1_done", done, 1);
    chk("c1_n", nsmp, 8);
    for (int i = 0; i < 8; i++) begin
      rd(i, 0, d);
      chk($sformatf("c1_rd%0d", i), d, 64'(16 + i));
    end
    rd(3, 1, d);
    chk("c1_rd_hi", d, 64'h0000_00C3);
    rd(8, 0, d);
    chk("c1_rd_oob", d, 0);
    rd_index = 2; rd_sel = 0; #1;
    chk("c1_rd_lat0", rd_data, 0);
    tick();
    chk("c1_rd_lat1", rd_data, 18);

    // Clock-enable freeze in WAIT, then abort+arm in POST.
    arm(4, 10);
    tickn(4);
    chk("c2_wait", state, 2);
    tickn(2);
    cke = 1'b0;
    tickn(5);
    chk("c2_frz_st", state, 2);
    chk("c2_frz_n", nsmp, 4);
    cke = 1'b1;
    trig = 4'b0001; tick(); trig = '0;
    chk("c2_post", state, 3);
    rd(0, 0, d);
    chk("c2_rd0", d, 3);
    rd(4, 0, d);
    chk("c2_rd_trg", d, 12);
    abort_i = 1'b1; arm_i = 1'b1; tick(); abort_i = 1'b0; arm_i = 1'b0;
    chk("c2_abrt_st", state, 0);
    chk("c2_abrt_n", nsmp, 0);
    arm(4, 10);
    chk("c2_rearm", state, 1);
    tickn(4);
    trig = 4'b0001; tick(); trig = '0;
    chk("c2_post2", state, 3);
    #2 arst = 1'b1;
    #1;
    chk("c2_arst_st", state, 0);
    chk("c2_arst_n", nsmp, 0);
    chk("c2_arst_tp", tpos, 0);
    tick(); arst = 1'b0;
    tick();
    chk("c2_arst_idle", state, 0);

    // AND mode with negate, pretrig = 0, posttrig = 0.
    mode = 1'b1; mask = 4'b0110; neg = 4'b0010; trig = 4'b0110;
    arm(0, 0);
    chk("c3_pre", state, 1);
    tick();
    chk("c3_wait", state, 2);
    chk("c3_wait_n", nsmp, 0);
    tick();
    chk("c3_nohit", state, 2);
    trig = 4'b0100; tick();
    chk("c3_hit", state, 4);
    chk("c3_n", nsmp, 1);
    rd(0, 0, d);
    chk("c3_rd", d, 3);
    mask = '0; trig = 4'b1111;
    arm(0, 0);
    tickn(10);
    chk("c3_m0_and", state, 2);
    mode = 1'b0;
    tickn(3);
    chk("c3_m0_or", state, 2);
    chk("c3_m0_done", done, 0);
    abort_i = 1'b1; tick(); abort_i = 1'b0;
    chk("c3_abort", state, 0);

    // Near-full pre-window: posttrig clamps to 3, buffer exactly full.
    mask = 4'b0001; neg = '0; trig = '0;
    arm(1020, 100);
    tickn(1020);
    chk("c4_wait", state, 2);
    chk("c4_wait_n", nsmp, 1020);
    trig = 4'b0001; tick(); trig = '0;
    chk("c4_tpos", tpos, 1020);
    chk("c4_post_n", nsmp, 1021);
    tickn(3);
    chk("c4_done", state, 4);
    chk("c4_n", nsmp, 1024);
    rd(1020, 0, d);
    chk("c4_rd_trg", d, 1021);
    rd(0, 0, d);
    chk("c4_rd0", d, 1);
    rd(1023, 0, d);
    chk("c4_rd_last", d, 1024);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
